// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_pkg
// Description : 640x480@60 raster constants, counter widths, the registered
//               control-flag bundle and a sync-window helper.
// Revision    : 1.0  initial release
// ============================================================================
package vga_timing_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Widths of the pixel-coordinate ports (raw counter values).
  localparam int H_CNT_W  = $clog2(H_TOTAL);
  localparam int V_CNT_W  = $clog2(V_TOTAL);

  // Single-bit outputs that are registered together.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic video_on;
    logic line_start;
    logic frame_start;
  } vga_ctl_t;

  // True when lo <= val < lo+len (unsigned).
  function automatic logic in_window(input logic [15:0] val,
                                     input logic [15:0] lo,
                                     input logic [15:0] len);
    return (val >= lo) && (val < (lo + len));
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_pix_tick.sv
`default_nettype none
// ============================================================================
// Module      : vga_pix_tick
// Description : Divide-by-CLK_DIV clock enable. adv is high during the clk
//               cycle whose edge should advance the raster counters.
// Revision    : 1.0  initial release
// ============================================================================
module vga_pix_tick
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic adv
);

  // CLK_DIV=1 still needs a 1-bit counter; it simply stays at zero.
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div_cnt_q;
  logic [DW-1:0] div_cnt_d;

  assign adv = (div_cnt_q == DW'(CLK_DIV - 1));

  // Count 0..CLK_DIV-1 and wrap.
  always_comb begin
    div_cnt_d = div_cnt_q + 1'b1;
    if (adv) begin
      div_cnt_d = '0;
    end
  end

  // Divider state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/vga_sync_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_sync_gen
// Description : VGA raster timing generator running from the board clock with
//               a pixel clock-enable. All outputs are registered and decoded
//               from the next counter values so they move with the counters.
//               Optional macro VGA_FRAME_CNT_EN adds the 8-bit frame_cnt port.
// Revision    : 1.0  initial release
// ============================================================================
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int   CLK_DIV  = 4,
  parameter int   H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int   H_FP     = vga_timing_pkg::H_FP,
  parameter int   H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int   H_BP     = vga_timing_pkg::H_BP,
  parameter int   V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int   V_FP     = vga_timing_pkg::V_FP,
  parameter int   V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int   V_BP     = vga_timing_pkg::V_BP,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               pix_tick,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic [H_CNT_W-1:0] pix_x,
  output logic [V_CNT_W-1:0] pix_y,
  output logic               line_start,
  output logic               frame_start
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [7:0]         frame_cnt
`endif
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);

  logic               adv;
  logic [HW-1:0]      h_cnt_q, h_cnt_d;
  logic [VW-1:0]      v_cnt_q, v_cnt_d;
  vga_ctl_t           ctl_q, ctl_d;
  logic               pix_tick_q;
  logic [H_CNT_W-1:0] pix_x_q;
  logic [V_CNT_W-1:0] pix_y_q;

  vga_pix_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_tick (
    .clk   (clk),
    .reset (reset),
    .adv   (adv)
  );

  // Next raster position; hold between pixel enables.
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (adv) begin
      if (h_cnt_q == HW'(H_TOT - 1)) begin
        h_cnt_d = '0;
        if (v_cnt_q == VW'(V_TOT - 1)) begin
          v_cnt_d = '0;
        end else begin
          v_cnt_d = v_cnt_q + 1'b1;
        end
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
      end
    end
  end

  // Decode outputs from the next position so they change with the counters.
  always_comb begin
    ctl_d.hsync       = in_window(16'(h_cnt_d), 16'(H_ACTIVE + H_FP), 16'(H_SYNC))
                        ? SYNC_POL : ~SYNC_POL;
    ctl_d.vsync       = in_window(16'(v_cnt_d), 16'(V_ACTIVE + V_FP), 16'(V_SYNC))
                        ? SYNC_POL : ~SYNC_POL;
    ctl_d.video_on    = (h_cnt_d < HW'(H_ACTIVE)) && (v_cnt_d < VW'(V_ACTIVE));
    ctl_d.line_start  = adv && (h_cnt_d == '0);
    ctl_d.frame_start = adv && (h_cnt_d == '0) && (v_cnt_d == '0);
  end

  // Counter and output registers; reset parks the raster on the last pixel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt_q           <= HW'(H_TOT - 1);
      v_cnt_q           <= VW'(V_TOT - 1);
      pix_tick_q        <= 1'b0;
      pix_x_q           <= H_CNT_W'(H_TOT - 1);
      pix_y_q           <= V_CNT_W'(V_TOT - 1);
      ctl_q.hsync       <= ~SYNC_POL;
      ctl_q.vsync       <= ~SYNC_POL;
      ctl_q.video_on    <= 1'b0;
      ctl_q.line_start  <= 1'b0;
      ctl_q.frame_start <= 1'b0;
    end else begin
      h_cnt_q    <= h_cnt_d;
      v_cnt_q    <= v_cnt_d;
      pix_tick_q <= adv;
      pix_x_q    <= H_CNT_W'(h_cnt_d);
      pix_y_q    <= V_CNT_W'(v_cnt_d);
      ctl_q      <= ctl_d;
    end
  end

  assign pix_tick    = pix_tick_q;
  assign hsync       = ctl_q.hsync;
  assign vsync       = ctl_q.vsync;
  assign video_on    = ctl_q.video_on;
  assign line_start  = ctl_q.line_start;
  assign frame_start = ctl_q.frame_start;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;

`ifdef VGA_FRAME_CNT_EN
  logic [7:0] frame_cnt_q;

  // Frames since reset, bumped on the edge that raises frame_start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt_q <= 8'd0;
    end else if (ctl_d.frame_start) begin
      frame_cnt_q <= frame_cnt_q + 8'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule
`default_nettype wire
